// File: rtl/fpu_pkg.sv
// Shared types, constants and helpers for the FP32 add/subtract sequencer.
package fpu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam int          EXP_MAX = 255;
   localparam int          MANT_W  = 24;
   localparam int          GRS_W   = 3;

   typedef struct packed {
      logic              sign;
      logic [7:0]        exp;
      logic [MANT_W-1:0] mant;
      logic              is_zero;
      logic              is_inf;
      logic              is_nan;
   } operand_t;

   // Denormals are flushed: a zero exponent means the operand is zero.
   function automatic operand_t unpack_fp(input logic [31:0] x);
      operand_t u;
      u.sign    = x[31];
      u.exp     = x[30:23];
      u.is_zero = (x[30:23] == 8'h00);
      u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
      u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
      u.mant    = u.is_zero ? '0 : {1'b1, x[22:0]};
      return u;
   endfunction

   // 32-bit leading-zero counter; returns 32 for an all-zero input.
   function automatic logic [5:0] lzc32(input logic [31:0] x);
      logic [5:0] n;
      n = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (x[i]) n = 6'(31 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_addsub_sequencer_if.sv
// Operand/result handshake bundle between FPU issue logic, the add/sub unit and writeback.
interface fp_addsub_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic        op_sub;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_ovf;
   logic        flag_unf;
   logic        flag_inv;
   logic        busy;

   modport master (
      output in_valid, op_sub, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv, busy
   );

   modport slave (
      input  in_valid, op_sub, op_a, op_b, out_ready,
      output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv, busy
   );
endinterface

// File: rtl/fp_align_shift.sv
// 27-bit right shifter for mantissa alignment; shifted-out bits collapse into the sticky LSB.
module fp_align_shift
   import fpu_pkg::*;
(
   input  logic [MANT_W+GRS_W-1:0] din,
   input  logic [7:0]              shamt,
   output logic [MANT_W+GRS_W-1:0] dout
);
   localparam int EXT_W = MANT_W + GRS_W;

   logic [4:0]       amt;
   logic [EXT_W-1:0] mask;
   logic [EXT_W-1:0] shifted;
   logic             sticky;

   // A shift of 26 already parks the hidden bit in S, so larger amounts saturate there.
   always_comb begin
      amt     = (shamt > 8'd26) ? 5'd26 : shamt[4:0];
      mask    = ~({EXT_W{1'b1}} << amt);
      sticky  = |(din & mask);
      shifted = din >> amt;
      dout    = {shifted[EXT_W-1:1], shifted[0] | sticky};
   end
endmodule

// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle FP32 add/subtract with valid/ready on both sides, one operation in flight.
// Optional macro FPU_ROUND_NEAREST_EN: round-to-nearest-even; otherwise results are truncated.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// ALIGN | cycle 1: unpack + special check + order by magnitude; cycle 0: align smaller mantissa
// ADD   | add/subtract the aligned 27-bit mantissas
// NORM  | normalize, round, pack into result registers
// DONE  | result held until out_ready
module fp_addsub_sequencer
   import fpu_pkg::*;
#(
   parameter int LAT_FIXED = 1
)
(
   input logic                  clk,
   input logic                  rst,
   fp_addsub_sequencer_if.slave bus
);
   localparam int EXT_W = MANT_W + GRS_W;

   state_t            state, state_nxt;
   logic              align_cnt;
   logic              accept;
   logic [31:0]       raw_a, raw_b;
   operand_t          ua, ub;
   logic              a_ge;
   logic              spec_hit, spec_inv;
   logic [31:0]       spec_res;
   logic              spec_hit_q, spec_inv_q;
   logic [31:0]       spec_res_q;
   logic              big_sign, small_sign;
   logic [7:0]        big_exp, exp_diff;
   logic [MANT_W-1:0] big_mant, small_mant;
   logic [EXT_W-1:0]  small_shift, small_ext;
   logic [EXT_W:0]    sum_q;
   logic [5:0]        lz;
   logic [EXT_W-1:0]  m_norm;
   logic signed [9:0] e_norm, e_fin;
   logic [MANT_W-1:0] mant_fin;
   logic [31:0]       pack_res;
   logic              pack_ovf, pack_unf, pack_inv;
   logic              load_res;
   logic [31:0]       result_q;
   logic              ovf_q, unf_q, inv_q;
   logic              unused_bits;

   assign accept = (state == IDLE) && bus.in_valid;
   assign ua     = unpack_fp(raw_a);
   assign ub     = unpack_fp(raw_b);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
            if (bus.in_valid) state_nxt = ALIGN;
         end
         ALIGN: begin
            if (align_cnt == 1'b0) begin
               if (LAT_FIXED == 0 && spec_hit_q) state_nxt = DONE;
               else                              state_nxt = ADD;
            end
         end
         ADD:  state_nxt = NORM;
         NORM: state_nxt = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ALIGN runs two cycles, paced by a down-counter that terminates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      align_cnt <= 1'b0;
      else if (accept)                              align_cnt <= 1'b1;
      else if (state == ALIGN && align_cnt != 1'b0) align_cnt <= align_cnt - 1'b1;
   end

   // Capture operands; B carries its effective sign so subtraction becomes addition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_a <= '0;
         raw_b <= '0;
      end else if (accept) begin
         raw_a <= bus.op_a;
         raw_b <= {bus.op_b[31] ^ bus.op_sub, bus.op_b[30:0]};
      end
   end

   // Special-operand classification and magnitude ordering.
   always_comb begin
      a_ge     = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
      spec_hit = 1'b1;
      spec_inv = 1'b0;
      spec_res = '0;
      if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
         spec_res = QNAN;
         spec_inv = 1'b1;
      end else if (ua.is_inf) begin
         spec_res = {ua.sign, POS_INF[30:0]};
      end else if (ub.is_inf) begin
         spec_res = {ub.sign, POS_INF[30:0]};
      end else if (ua.is_zero && ub.is_zero) begin
         spec_res = {ua.sign & ub.sign, 31'h0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // First ALIGN cycle: register the special outcome and the larger/smaller operand split.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spec_hit_q <= 1'b0;
         spec_inv_q <= 1'b0;
         spec_res_q <= '0;
         big_sign   <= 1'b0;
         big_exp    <= '0;
         big_mant   <= '0;
         small_sign <= 1'b0;
         small_mant <= '0;
         exp_diff   <= '0;
      end else if (state == ALIGN && align_cnt == 1'b1) begin
         spec_hit_q <= spec_hit;
         spec_inv_q <= spec_inv;
         spec_res_q <= spec_res;
         if (a_ge) begin
            big_sign   <= ua.sign;
            big_exp    <= ua.exp;
            big_mant   <= ua.mant;
            small_sign <= ub.sign;
            small_mant <= ub.mant;
            exp_diff   <= ua.exp - ub.exp;
         end else begin
            big_sign   <= ub.sign;
            big_exp    <= ub.exp;
            big_mant   <= ub.mant;
            small_sign <= ua.sign;
            small_mant <= ua.mant;
            exp_diff   <= ub.exp - ua.exp;
         end
      end
   end

   fp_align_shift u_align (
      .din   ({small_mant, {GRS_W{1'b0}}}),
      .shamt (exp_diff),
      .dout  (small_shift)
   );

   // Second ALIGN cycle registers the aligned mantissa; ADD registers the sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         small_ext <= '0;
         sum_q     <= '0;
      end else if (state == ALIGN && align_cnt == 1'b0) begin
         small_ext <= small_shift;
      end else if (state == ADD) begin
         if (big_sign ^ small_sign) sum_q <= {1'b0, big_mant, {GRS_W{1'b0}}} - {1'b0, small_ext};
         else                       sum_q <= {1'b0, big_mant, {GRS_W{1'b0}}} + {1'b0, small_ext};
      end
   end

   // Normalize: carry shifts right by one, otherwise shift left by the leading-zero count.
   always_comb begin
      lz = lzc32({sum_q[EXT_W-1:0], 5'b0});
      if (sum_q[EXT_W]) begin
         m_norm = {sum_q[EXT_W:2], sum_q[1] | sum_q[0]};
         e_norm = $signed({2'b00, big_exp}) + 10'sd1;
      end else begin
         m_norm = sum_q[EXT_W-1:0] << lz;
         e_norm = $signed({2'b00, big_exp}) - $signed({4'b0000, lz});
      end
   end

`ifdef FPU_ROUND_NEAREST_EN
   logic [MANT_W:0] mant_rnd;
   logic            rnd_inc;

   // Round to nearest even; a carry out of the mantissa bumps the exponent.
   always_comb begin
      rnd_inc  = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
      mant_rnd = {1'b0, m_norm[EXT_W-1:GRS_W]} + {{MANT_W{1'b0}}, rnd_inc};
      if (mant_rnd[MANT_W]) begin
         mant_fin = mant_rnd[MANT_W:1];
         e_fin    = e_norm + 10'sd1;
      end else begin
         mant_fin = mant_rnd[MANT_W-1:0];
         e_fin    = e_norm;
      end
   end

   assign unused_bits = mant_fin[MANT_W-1];
`else
   // Truncate: guard, round and sticky are dropped.
   always_comb begin
      mant_fin = m_norm[EXT_W-1:GRS_W];
      e_fin    = e_norm;
   end

   assign unused_bits = ^{mant_fin[MANT_W-1], m_norm[GRS_W-1:0]};
`endif

   // Pack, applying special results and exponent range limits.
   always_comb begin
      pack_res = '0;
      pack_ovf = 1'b0;
      pack_unf = 1'b0;
      pack_inv = 1'b0;
      if (spec_hit_q) begin
         pack_res = spec_res_q;
         pack_inv = spec_inv_q;
      end else if (sum_q == '0) begin
         pack_res = '0;
      end else if (e_fin <= 10'sd0) begin
         pack_res = {big_sign, 31'h0};
         pack_unf = 1'b1;
      end else if (e_fin >= $signed(10'(EXP_MAX))) begin
         pack_res = {big_sign, POS_INF[30:0]};
         pack_ovf = 1'b1;
      end else begin
         pack_res = {big_sign, e_fin[7:0], mant_fin[MANT_W-2:0]};
      end
   end

   assign load_res = (state == NORM) ||
                     (state == ALIGN && align_cnt == 1'b0 && spec_hit_q && LAT_FIXED == 0);

   // Result and flag registers, held through DONE until the consumer takes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else if (load_res) begin
         result_q <= pack_res;
         ovf_q    <= pack_ovf;
         unf_q    <= pack_unf;
         inv_q    <= pack_inv;
      end
   end

   assign bus.result   = result_q;
   assign bus.flag_ovf = ovf_q;
   assign bus.flag_unf = unf_q;
   assign bus.flag_inv = inv_q;
endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed bench for fp_addsub_sequencer: vector table plus handshake/reset sequences.
module tb_fp_addsub_sequencer;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic [2:0]  flags;   // {ovf, unf, inv}
   } vec_t;

`ifdef FPU_ROUND_NEAREST_EN
   localparam logic [31:0] RND_EXP = 32'h3F80_0001;
`else
   localparam logic [31:0] RND_EXP = 32'h3F80_0000;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   vec_t vecs[$];

   fp_addsub_sequencer_if bus ();

   fp_addsub_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp_v);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] res, output logic [2:0] flags, output int lat);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_sub   = sub;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_out(lat);
      res   = bus.result;
      flags = {bus.flag_ovf, bus.flag_unf, bus.flag_inv};
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] res;
      logic [2:0]  flags;
      int          lat;
      int          seen_ov;

      n_checks = 0;
      n_pass   = 0;
      clk      = 1'b0;
      rst      = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_sub    = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.out_ready = 1'b0;

      vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000});
      vecs.push_back('{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000});
      vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000});
      vecs.push_back('{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 3'b000});
      vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100});
      vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001});
      vecs.push_back('{32'h3F800000, 32'h33C00000, 1'b0, RND_EXP,      3'b000});
      vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000});
      vecs.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001});
      vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000});
      vecs.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000});
      vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000});
      vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010});
      vecs.push_back('{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000});
      vecs.push_back('{32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b001});
      vecs.push_back('{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 3'b000});
      vecs.push_back('{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000});
      vecs.push_back('{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000});
      vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000});

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready",  32'(bus.in_ready),  32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result",    bus.result,         32'h0);
      check("reset flags",     32'({bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 32'd0);
      check("reset busy",      32'(bus.busy),      32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // out_ready while idle has no effect
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle out_ready out_valid", 32'(bus.out_valid), 32'd0);
      check("idle out_ready in_ready",  32'(bus.in_ready),  32'd1);
      bus.out_ready = 1'b0;

      // vector table
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, flags, lat);
         check($sformatf("vec%0d result", i),  res,          vecs[i].res);
         check($sformatf("vec%0d flags", i),   32'(flags),   32'(vecs[i].flags));
         check($sformatf("vec%0d latency", i), 32'(lat),     32'd4);
      end

      // backpressure: result held, new requests ignored while DONE
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h3F800000;
      bus.op_b     = 32'h3F800000;
      bus.op_sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_out(lat);
      check("bp latency", 32'(lat), 32'd4);
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1;
         bus.op_a     = 32'h40000000;
         bus.op_b     = 32'h40000000;
         @(posedge clk);
         #1;
         check($sformatf("bp%0d result", c),    bus.result,         32'h40000000);
         check($sformatf("bp%0d flags", c),     32'({bus.flag_ovf, bus.flag_unf, bus.flag_inv}), 32'd0);
         check($sformatf("bp%0d in_ready", c),  32'(bus.in_ready),  32'd0);
         check($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp after hs out_valid", 32'(bus.out_valid), 32'd0);
      check("bp after hs in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp next accepted busy", 32'(bus.busy), 32'd1);
      wait_out(lat);
      check("bp next latency", 32'(lat), 32'd4);
      check("bp next result", bus.result, 32'h40800000);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;

      // reset asserted while in NORM
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h3F800000;
      bus.op_b     = 32'h3F800000;
      bus.op_sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre-rst busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst in_ready",  32'(bus.in_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      seen_ov = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen_ov++;
      end
      check("post-rst no out_valid", 32'(seen_ov), 32'd0);
      check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
      run_op(32'h40000000, 32'h40000000, 1'b0, res, flags, lat);
      check("post-rst result",  res,        32'h40800000);
      check("post-rst flags",   32'(flags), 32'd0);
      check("post-rst latency", 32'(lat),   32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
